event_stretcher: RTL

//   Converts one-tick event pulses (e.g. debounced ondn/onup strobes) back into

---
 rtl/event_stretcher.sv | 124 ++++++++++++
 1 files changed

// File: rtl/event_stretcher.sv
// event_stretcher: turns one-tick event strobes into fixed-width visible
// pulses separated by a mandatory gap, queueing events that arrive mid-pulse.
module event_stretcher #(
  parameter int ON_TICKS  = 25_000_000,
  parameter int GAP_TICKS = 12_500_000,
  parameter int PEND_MAX  = 7,
  localparam int PW = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          evt,
  input  logic          ovf_clr,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pend,
  output logic          ovf
);

  localparam int MAXT = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] ON_LD  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_TICKS - 1);
  localparam logic [PW-1:0] PMAX   = PW'(PEND_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pend;
  logic          r_ovf;

  logic [1:0]    w_state;
  logic [CW-1:0] w_cnt;
  logic [PW-1:0] w_pend;
  logic          w_last;
  logic          w_full;
  logic          w_drop;

  assign w_last = (r_state == S_GAP) && (r_cnt == '0);
  assign w_full = (r_pend == PMAX);
  assign w_drop = (r_state != S_IDLE) && !w_last && evt && w_full;

  // Next state, countdown reload and pending-queue bookkeeping.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_pend  = r_pend;
    case (r_state)
      S_IDLE: begin
        if (evt) begin
          w_state = S_ON;
          w_cnt   = ON_LD;
        end
      end
      S_ON: begin
        if (r_cnt == '0) begin
          w_state = S_GAP;
          w_cnt   = GAP_LD;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
        if (evt && !w_full) begin
          w_pend = r_pend + 1'b1;
        end
      end
      S_GAP: begin
        if (w_last) begin
          if (evt || (r_pend != '0)) begin
            w_state = S_ON;
            w_cnt   = ON_LD;
            if (!evt) begin
              w_pend = r_pend - 1'b1;
            end
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt - 1'b1;
          if (evt && !w_full) begin
            w_pend = r_pend + 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_pend  = '0;
      end
    endcase
  end

  // State, counter and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_pend  <= w_pend;
    end
  end

  // Sticky overflow flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign out  = (r_state == S_ON);
  assign busy = (r_state != S_IDLE);
  assign pend = r_pend;
  assign ovf  = r_ovf;

endmodule
